// File: rtl/cnn16_pkg.sv
// Shared types and constants for the CNN_16 program loader / run sequencer.
package cnn16_pkg;
  localparam int MEM_ADDR_W = 12;
  localparam int WORD_W     = 16;

  localparam logic [WORD_W-1:0] OP_BRK     = 16'hF000;
  localparam logic [WORD_W-1:0] STREAM_END = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE, TOUT, ERR} state_t;
endpackage

// File: rtl/cnn16_run_watchdog.sv
// RUN-phase cycle counter with synchronous clear, enable and terminal-count flag.
module cnn16_run_watchdog #(
  parameter int W  = 16,
  parameter int TC = 1024
) (
  input  logic         clkn,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(TC - 1);

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn)    count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign tc = (count == LAST);
endmodule

// File: rtl/cnn16_load_ctrl.sv
// Streams a host program into CNN_16 memory, releases the core and watches for BRK or timeout.
module cnn16_load_ctrl
  import cnn16_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = 12'h010,
  parameter logic [WORD_W-1:0]     END_WORD  = STREAM_END,
  parameter logic [WORD_W-1:0]     HALT_IR   = OP_BRK,
  parameter int                    TIMEOUT   = 1024
) (
  input  logic                  clkn,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [WORD_W-1:0]     word_data,
  output logic                  word_ready,
  input  logic [MEM_ADDR_W-1:0] pc_value,
  input  logic [WORD_W-1:0]     ir_value,
  output logic                  cpu_rstn,
  output logic                  sel_out,
  output logic                  we_out,
  output logic [MEM_ADDR_W-1:0] adr_out,
  output logic [WORD_W-1:0]     data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  load_err,
  output logic [MEM_ADDR_W-1:0] words_loaded,
  output logic [15:0]           run_cycles,
  output logic [MEM_ADDR_W-1:0] halt_pc
);
  state_t state, nxt;
  // Extra MSB marks that the top address has been written; the pointer never wraps.
  logic [MEM_ADDR_W:0] ptr;
  logic hs, is_end, wr, go, halt, run_tc, tc;

  assign hs     = word_valid && (state == LOAD);
  assign is_end = (word_data == END_WORD);
  assign wr     = hs && !is_end && !ptr[MEM_ADDR_W] && !abort;
  assign go     = start && (state inside {IDLE, DONE, TOUT, ERR});
  assign halt   = (state == RUN) && (ir_value == HALT_IR);
  assign run_tc = (state == RUN) && tc;

  cnn16_run_watchdog #(.W(16), .TC(TIMEOUT)) u_wdog (
    .clkn  (clkn),
    .rstn  (rstn),
    .clr   (go && !abort),
    .en    ((state == RUN) && !halt && !tc && !abort),
    .count (run_cycles),
    .tc    (tc)
  );

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, TOUT, ERR: if (start) nxt = LOAD;
      LOAD: if (hs) begin
        if (is_end)                nxt = RELEASE;
        else if (ptr[MEM_ADDR_W])  nxt = ERR;
      end
      RELEASE: nxt = RUN;
      RUN: if (ir_value == HALT_IR) nxt = DONE;
           else if (tc)             nxt = TOUT;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  always_comb begin
    word_ready = (state == LOAD);
    cpu_rstn   = (state == RUN);
    sel_out    = (state != RUN);
    busy       = state inside {LOAD, RELEASE, RUN};
  end

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      ptr          <= {1'b0, BASE_ADDR};
      we_out       <= 1'b0;
      adr_out      <= BASE_ADDR;
      data_out     <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      halt_pc      <= '0;
    end else begin
      we_out <= 1'b0;
      if (abort) begin
        done     <= 1'b0;
        timeout  <= 1'b0;
        load_err <= 1'b0;
      end else begin
        if (go) begin
          ptr          <= {1'b0, BASE_ADDR};
          words_loaded <= '0;
          done         <= 1'b0;
          timeout      <= 1'b0;
          load_err     <= 1'b0;
        end
        if (wr) begin
          adr_out      <= ptr[MEM_ADDR_W-1:0];
          data_out     <= word_data;
          we_out       <= 1'b1;
          ptr          <= ptr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        if (hs && !is_end && ptr[MEM_ADDR_W]) load_err <= 1'b1;
        if (halt) begin
          done    <= 1'b1;
          halt_pc <= pc_value;
        end else if (run_tc) begin
          timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn16_load_ctrl.sv
// Randomized scoreboard bench for cnn16_load_ctrl; base sits near the top of memory.
module tb_cnn16_load_ctrl;
  localparam logic [11:0] BASE = 12'hFF0;
  localparam int          TMO  = 16;
  localparam logic [15:0] HALT = 16'hF000;
  localparam logic [15:0] TERM = 16'hFFFF;

  logic        clkn = 1'b0, rstn = 1'b1, start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [15:0] word_data = '0, ir_value = '0;
  logic [11:0] pc_value = '0;
  logic        word_ready, cpu_rstn, sel_out, we_out, busy, done, timeout, load_err;
  logic [11:0] adr_out, words_loaded, halt_pc;
  logic [15:0] data_out, run_cycles;

  int n_chk = 0, n_fail = 0;
  int nw;
  logic [11:0] exp_adr_q[$];
  logic [15:0] exp_dat_q[$];

  cnn16_load_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clkn(clkn), .rstn(rstn), .start(start), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .pc_value(pc_value), .ir_value(ir_value), .cpu_rstn(cpu_rstn), .sel_out(sel_out),
    .we_out(we_out), .adr_out(adr_out), .data_out(data_out), .busy(busy),
    .done(done), .timeout(timeout), .load_err(load_err),
    .words_loaded(words_loaded), .run_cycles(run_cycles), .halt_pc(halt_pc)
  );

  always #5 clkn = ~clkn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-port monitor: every we_out pulse must match the next expected write.
  always @(negedge clkn) begin
    if (rstn && we_out) begin
      if (exp_adr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_write: adr %0h data %0h, none expected at %0t", adr_out, data_out, $time);
      end else begin
        chk("write_adr", adr_out, exp_adr_q.pop_front());
        chk("write_data", data_out, exp_dat_q.pop_front());
        chk("sel_during_write", sel_out, 1);
      end
    end
  end

  task automatic cyc();
    @(posedge clkn);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sel"}, sel_out, 1);
    chk({tag, "_cpu_rstn"}, cpu_rstn, 0);
    chk({tag, "_adr"}, adr_out, BASE);
    chk({tag, "_we"}, we_out, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_ready"}, word_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_words"}, words_loaded, 0);
    chk({tag, "_run_cycles"}, run_cycles, 0);
    chk({tag, "_halt_pc"}, halt_pc, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    @(negedge clkn);
    chk("start_busy", busy, 1);
    chk("start_ready", word_ready, 1);
    chk("start_words_clr", words_loaded, 0);
    chk("start_done_clr", done, 0);
    chk("start_tout_clr", timeout, 0);
    chk("start_err_clr", load_err, 0);
    nw = 0;
  endtask

  // Word i of a load lands at BASE+i, unless that would pass the top of memory.
  task automatic send(input logic [15:0] w);
    int a;
    a = int'(BASE) + nw;
    word_valid = 1'b1;
    word_data  = w;
    start      = ($urandom_range(0, 7) == 0);
    if (a <= 4095) begin
      exp_adr_q.push_back(12'(a));
      exp_dat_q.push_back(w);
      nw++;
    end
    cyc();
    word_valid = 1'b0;
    start      = 1'b0;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) cyc();
  endtask

  task automatic run_prog(input logic [15:0] prog[$], input int halt_at);
    int          last;
    logic [11:0] hpc;
    logic        exp_done;
    last     = (halt_at < TMO) ? halt_at : TMO;
    exp_done = (halt_at <= TMO);
    hpc      = '0;
    do_start();
    foreach (prog[i]) send(prog[i]);
    word_valid = 1'b1;
    word_data  = TERM;
    cyc();
    word_valid = 1'b0;
    @(negedge clkn);
    chk("release_cpu_rstn", cpu_rstn, 0);
    chk("release_sel", sel_out, 1);
    chk("release_busy", busy, 1);
    chk("release_ready", word_ready, 0);
    chk("words_loaded", words_loaded, prog.size());
    @(posedge clkn);
    #1;
    for (int c = 1; c <= last; c++) begin
      pc_value = 12'($urandom);
      if (c == halt_at) begin
        ir_value = HALT;
        hpc      = pc_value;
      end else begin
        ir_value = 16'($urandom);
        if (ir_value == HALT) ir_value = 16'h0000;
      end
      if (c == 1) begin
        @(negedge clkn);
        chk("run_cpu_rstn", cpu_rstn, 1);
        chk("run_sel", sel_out, 0);
      end
      @(posedge clkn);
      #1;
    end
    ir_value = '0;
    @(negedge clkn);
    chk("end_done", done, exp_done);
    chk("end_timeout", timeout, !exp_done);
    chk("end_run_cycles", run_cycles, last - 1);
    chk("end_busy", busy, 0);
    chk("end_sel", sel_out, 1);
    chk("end_cpu_rstn", cpu_rstn, 0);
    if (exp_done) chk("end_halt_pc", halt_pc, hpc);
  endtask

  initial begin
    logic [15:0] prog[$];
    #1 rstn = 1'b0;
    #2 check_reset("reset");
    @(negedge clkn);
    rstn = 1'b1;

    prog = '{16'h3005, 16'h4010, 16'h500F, 16'hF000};
    run_prog(prog, 8);
    run_prog(prog, TMO + 5);
    run_prog(prog, TMO);
    prog.delete();
    run_prog(prog, 3);

    repeat (8) begin
      prog.delete();
      repeat ($urandom_range(0, 10)) prog.push_back(16'($urandom_range(0, 16'hFFFE)));
      run_prog(prog, $urandom_range(1, TMO + 4));
    end

    // Overrun the top of memory: 16 writes fit, the 17th word must error out.
    do_start();
    for (int i = 0; i < 17; i++) send(16'($urandom_range(0, 16'hFFFE)));
    @(negedge clkn);
    chk("ovf_load_err", load_err, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_words", words_loaded, 16);
    chk("ovf_ready", word_ready, 0);
    chk("ovf_cpu_rstn", cpu_rstn, 0);

    // Abort on the second word: that word is dropped, the count is kept.
    do_start();
    send(16'h1234);
    word_valid = 1'b1;
    word_data  = 16'h5678;
    abort      = 1'b1;
    cyc();
    word_valid = 1'b0;
    abort      = 1'b0;
    @(negedge clkn);
    chk("abort_busy", busy, 0);
    chk("abort_we", we_out, 0);
    chk("abort_words", words_loaded, 1);
    chk("abort_cpu_rstn", cpu_rstn, 0);

    // Rerun, then yank reset asynchronously in the middle of RUN.
    do_start();
    send(16'h0A0A);
    send(16'h0B0B);
    word_valid = 1'b1;
    word_data  = TERM;
    cyc();
    word_valid = 1'b0;
    repeat (4) cyc();
    chk("pre_rst_cpu_rstn", cpu_rstn, 1);
    #2 rstn = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clkn);
    rstn = 1'b1;
    repeat (2) cyc();
    chk("pending_writes", exp_adr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
